alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the datapath's single-cycle combinational ALU.
- Adds XOR, three shifts and an iterative unsigned multiply.
- Registers result and NZCV flags behind a valid/ready handshake so the execute stage can stall on long operations.
- Sits between the register-read pipeline register and the execute/memory pipeline register.

---
 rtl/alu_mc.sv | 160 ++++++++++++++++
 tb/tb_alu_mc.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with registered result and NZCV flags behind a valid/ready handshake.
// Single-cycle ops complete on the accept edge; MUL runs an N-step radix-2 shift-add.
//
// state  | meaning
// IDLE   | waiting for a request
// MUL    | shift-add multiply in progress, busy asserted
// DONE   | result/flags valid, held until out_ready
module alu_mc #(
  parameter int N      = 32,
  parameter int SHW    = $clog2(N),
  parameter bit MUL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   alucontrol,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   flags,
  output logic         busy
);
  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   result_q, result_d;
  logic [3:0]     flags_q, flags_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;

  logic           inv;
  logic [N-1:0]   b_op;
  logic [N:0]     sum;
  logic           add_v;
  logic [SHW-1:0] shamt;
  logic [N:0]     sll_t, srl_t;
  logic signed [N:0] sra_in, sra_t;
  logic [N-1:0]   alu_res;
  logic           alu_c, alu_v;
  logic           is_mul, accept;
  logic [2*N-1:0] acc_nxt;

  // Shifts run one bit wider so the last bit shifted out lands in the extra bit.
  always_comb begin
    inv     = (alucontrol == 4'b0110) || (alucontrol == 4'b0111);
    b_op    = inv ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_op} + {{N{1'b0}}, inv};
    add_v   = (a[N-1] ~^ b_op[N-1]) & (a[N-1] ^ sum[N-1]);
    shamt   = b[SHW-1:0];
    sll_t   = {1'b0, a} << shamt;
    srl_t   = {a, 1'b0} >> shamt;
    sra_in  = {a, 1'b0};
    sra_t   = sra_in >>> shamt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alucontrol)
      4'b0000: alu_res = a & b;
      4'b0001: alu_res = a | b;
      4'b0011: alu_res = a ^ b;
      4'b0010, 4'b0110: begin
        alu_res = sum[N-1:0];
        alu_c   = sum[N];
        alu_v   = add_v;
      end
      4'b0111: alu_res = {{(N-1){1'b0}}, sum[N-1] ^ add_v};
      4'b0100: begin
        alu_res = sll_t[N-1:0];
        alu_c   = sll_t[N];
      end
      4'b0101: begin
        alu_res = srl_t[N:1];
        alu_c   = srl_t[0];
      end
      4'b1000: begin
        alu_res = sra_t[N:1];
        alu_c   = sra_t[0];
      end
      default: ;
    endcase
  end

  assign is_mul  = MUL_EN && (alucontrol == 4'b1001);
  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL);
  assign result    = result_q;
  assign flags     = flags_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (is_mul) begin
            state_d  = S_MUL;
            cnt_d    = CW'(N);
            acc_d    = '0;
            mcand_d  = {{N{1'b0}}, a};
            mplier_d = b;
          end else begin
            state_d  = S_DONE;
            result_d = alu_res;
            flags_d  = {alu_res[N-1], ~|alu_res, alu_c, alu_v};
          end
        end else if (state_q == S_DONE && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = S_DONE;
          result_d = acc_nxt[N-1:0];
          flags_d  = {acc_nxt[N-1], ~|acc_nxt[N-1:0], 1'b0, |acc_nxt[2*N-1:N]};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: scoreboard of model results pushed on accept, popped on handshake,
// plus latency, busy, stall and reset checks.
module tb_alu_mc;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_valid0 = 1'b0, out_ready = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic [3:0]   op = '0;
  logic         in_ready, out_valid, busy;
  logic [N-1:0] result;
  logic [3:0]   flags;
  logic         in_ready0, out_valid0, busy0;
  logic [N-1:0] result0;
  logic [3:0]   flags0;

  alu_mc #(.N(N), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alucontrol(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .busy(busy));

  alu_mc #(.N(N), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a), .b(b), .alucontrol(op), .out_valid(out_valid0), .out_ready(out_ready),
    .result(result0), .flags(flags0), .busy(busy0));

  typedef struct packed {
    logic [N-1:0] res;
    logic [3:0]   fl;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y,
                                 input logic [3:0] o, input bit mul_en);
    exp_t e;
    logic [N:0] s;
    logic [2*N-1:0] p;
    logic c, v;
    int sh;
    sh = int'(y[4:0]);
    c = 1'b0;
    v = 1'b0;
    e.res = '0;
    case (o)
      4'b0000: e.res = x & y;
      4'b0001: e.res = x | y;
      4'b0011: e.res = x ^ y;
      4'b0010: begin
        s = {1'b0, x} + {1'b0, y};
        e.res = s[N-1:0];
        c = s[N];
        v = (x[N-1] == y[N-1]) && (s[N-1] != x[N-1]);
      end
      4'b0110: begin
        s = {1'b0, x} + {1'b0, ~y} + 33'd1;
        e.res = s[N-1:0];
        c = s[N];
        v = (x[N-1] != y[N-1]) && (s[N-1] != x[N-1]);
      end
      4'b0111: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b0100: begin
        e.res = x << sh;
        c = (sh == 0) ? 1'b0 : x[N-sh];
      end
      4'b0101: begin
        e.res = x >> sh;
        c = (sh == 0) ? 1'b0 : x[sh-1];
      end
      4'b1000: begin
        e.res = $signed(x) >>> sh;
        c = (sh == 0) ? 1'b0 : x[sh-1];
      end
      4'b1001: if (mul_en) begin
        p = {32'd0, x} * {32'd0, y};
        e.res = p[N-1:0];
        v = |p[2*N-1:N];
      end
      default: ;
    endcase
    e.fl = {e.res[N-1], e.res == '0, c, v};
    return e;
  endfunction

  // One clock: settle, score any handshake, then advance to just after the next rising edge.
  task automatic tick(output bit acc);
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        e = sbq.pop_front();
        chk("sb_result", 64'(result), 64'(e.res));
        chk("sb_flags", 64'(flags), 64'(e.fl));
      end
    end
    if (acc) sbq.push_back(model(a, b, op, 1'b1));
    @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    bit dummy;
    tick(dummy);
  endtask

  task automatic req(input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    bit acc;
    int n;
    op = o; a = x; b = y; in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      tick(acc);
      n++;
    end
    in_valid = 1'b0;
    if (!acc) chk("req_timeout", 64'd0, 64'd1);
  endtask

  // Issues one op with out_ready low, measures latency/busy, then consumes it.
  task automatic run(input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                     output int lat, output int bc,
                     output logic [N-1:0] r, output logic [3:0] f);
    out_ready = 1'b0;
    req(o, x, y);
    lat = 1;
    bc = 0;
    while (!out_valid && lat < 200) begin
      if (busy) bc++;
      tick1();
      lat++;
    end
    r = result;
    f = flags;
    out_ready = 1'b1;
    tick1();
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic [3:0] o, input logic [N-1:0] x,
                          input logic [N-1:0] y, input logic [N-1:0] er,
                          input logic [3:0] ef, input int elat);
    int lat, bc;
    logic [N-1:0] r;
    logic [3:0] f;
    run(o, x, y, lat, bc, r, f);
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_res"}, 64'(r), 64'(er));
    chk({tag, "_flags"}, 64'(f), 64'(ef));
    if (elat > 1) chk({tag, "_busy"}, 64'(bc), 64'(elat - 1));
  endtask

  initial begin
    logic [N-1:0] held_r;
    logic [3:0]   held_f;
    exp_t         last;
    bit           acc;
    logic [3:0]   ops [9];
    int lat, bc;
    logic [N-1:0] r;
    logic [3:0]   f;
    ops = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0100, 4'b0101, 4'b1000};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick1();
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    check_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001, 1);
    check_op("sub_zero", 4'b0110, 32'd5, 32'd5, 32'd0, 4'b0110, 1);
    check_op("slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0000, 1);
    check_op("sra", 4'b1000, 32'h8000_0001, 32'h21, 32'hC000_0000, 4'b1010, 1);
    check_op("sll0", 4'b0100, 32'h8000_0001, 32'h20, 32'h8000_0001, 4'b1000, 1);

    // Leave a nonzero result, then abort a multiply with reset.
    out_ready = 1'b0;
    req(4'b0001, 32'h1234_0000, 32'h0000_5678);
    out_ready = 1'b1;
    tick1();
    out_ready = 1'b0;
    req(4'b1001, 32'd3, 32'd5);
    repeat (9) tick1();
    chk("mid_mul_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_flags", 64'(flags), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick1();
    check_op("post_rst_add", 4'b0010, 32'd10, 32'd20, 32'd30, 4'b0000, 1);

    check_op("mul_hi", 4'b1001, 32'h0001_0000, 32'h0001_0000, 32'd0, 4'b0101, 33);
    check_op("mul_42", 4'b1001, 32'd7, 32'd6, 32'd42, 4'b0000, 33);

    for (int i = 0; i < 12; i++) begin
      run(ops[$urandom_range(0, 8)], $urandom, $urandom, lat, bc, r, f);
      chk("rand_lat", 64'(lat), 64'd1);
    end
    run(4'b1001, $urandom, $urandom, lat, bc, r, f);
    chk("rand_mul_lat", 64'(lat), 64'd33);

    // Back-to-back stream of ADDs with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op = 4'b0010; a = 32'h1000_0000 * (i + 1); b = 32'hFFFF_FFF0 + i; in_valid = 1'b1;
      tick(acc);
      chk("b2b_accept", 64'(acc), 64'd1);
      chk("b2b_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    last = model(32'h4000_0000, 32'hFFFF_FFF3, 4'b0010, 1'b1);
    held_r = result;
    held_f = flags;
    chk("b2b_last_res", 64'(held_r), 64'(last.res));
    for (int i = 0; i < 3; i++) begin
      op = 4'b0000; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1;
      tick(acc);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_result", 64'(result), 64'(last.res));
      chk("stall_flags", 64'(flags), 64'(last.fl));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick1();
    chk("stall_drain_idle", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    check_op("undef", 4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 4'b0100, 1);

    // MUL opcode on the MUL_EN=0 instance acts as an undefined opcode.
    op = 4'b1001; a = 32'd7; b = 32'd6; in_valid0 = 1'b1;
    #1;
    chk("nomul_in_ready", 64'(in_ready0), 64'd1);
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    chk("nomul_out_valid", 64'(out_valid0), 64'd1);
    chk("nomul_result", 64'(result0), 64'd0);
    chk("nomul_flags", 64'(flags0), 64'b0100);
    chk("nomul_busy", 64'(busy0), 64'd0);

    chk("sb_empty_end", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
